// File: rtl/wb_commit_pkg.sv
// Shared widths, RV32I load funct3 encodings and sign-extension helpers
// for the writeback/commit stage (wb_commit) and its load aligner.
// Latency: n/a (declarations only). Backpressure: n/a.
package wb_commit_pkg;

    localparam int DATA_W     = 32;   // register-file data width
    localparam int REG_ADDR_W = 5;    // register address width
    localparam int REG_NUM    = 32;   // number of architectural registers

    // Load funct3 encodings (RV32I)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    function automatic logic [DATA_W-1:0] sext8(input logic [7:0] b);
        return {{(DATA_W-8){b[7]}}, b};
    endfunction

    function automatic logic [DATA_W-1:0] sext16(input logic [15:0] h);
        return {{(DATA_W-16){h[15]}}, h};
    endfunction

endpackage

// File: rtl/wb_load_align.sv
// Load aligner: extracts and sign/zero-extends the byte, halfword or word
// selected by funct3/addr_lo from the raw memory word; flags bad loads.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: raw (memory word), funct3, addr_lo -> data (0 on error), err.
module wb_load_align
    import wb_commit_pkg::*;
(
    input  logic [DATA_W-1:0] raw,
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr_lo,
    output logic [DATA_W-1:0] data,
    output logic              err
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = raw[7:0];
            2'd1:    byte_sel = raw[15:8];
            2'd2:    byte_sel = raw[23:16];
            default: byte_sel = raw[31:24];
        endcase
        half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];
    end

    // Errored loads return zero so nothing stale leaks into wdata.
    always_comb begin
        data = '0;
        err  = 1'b0;
        case (funct3)
            F3_LB:  data = sext8(byte_sel);
            F3_LBU: data = {{(DATA_W-8){1'b0}}, byte_sel};
            F3_LH: begin
                if (addr_lo[0]) err  = 1'b1;
                else            data = sext16(half_sel);
            end
            F3_LHU: begin
                if (addr_lo[0]) err  = 1'b1;
                else            data = {{(DATA_W-16){1'b0}}, half_sel};
            end
            F3_LW: begin
                if (addr_lo != 2'd0) err  = 1'b1;
                else                 data = raw;
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_commit.sv
// Writeback/commit stage: drives the register-file write port from MEM
// results and keeps a per-register pending-write scoreboard for decode.
// Latency: we/waddr/wdata/ld_err registered 1 cycle after accept.
// Backpressure: mem_ready drops on rst or wb_stall; iss_ready drops when
// the destination's in-flight counter is saturated.
// Ports: clk/rst; mem_* result handshake; wb_stall; we/waddr/wdata/ld_err
// register-file port; iss_* issue handshake; q_r1/q_r2 -> q_busy1/q_busy2.
// Optional: define WB_INSTRET_EN to add the 64-bit instret output
// counting every accepted result.
module wb_commit
    import wb_commit_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    // MEM-stage result
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic                  mem_rd_we,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_is_load,
    input  logic [2:0]            mem_funct3,
    input  logic [1:0]            mem_addr_lo,
    input  logic [DATA_W-1:0]     mem_result,
    input  logic                  wb_stall,
    // register-file write port
    output logic                  we,
    output logic [REG_ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0]     wdata,
    output logic                  ld_err,
`ifdef WB_INSTRET_EN
    output logic [63:0]           instret,
`endif
    // decode issue / operand query
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    output logic                  iss_ready,
    input  logic [REG_ADDR_W-1:0] q_r1,
    input  logic [REG_ADDR_W-1:0] q_r2,
    output logic                  q_busy1,
    output logic                  q_busy2
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                  accept;
    logic [DATA_W-1:0]     ld_data;
    logic                  ld_bad;
    logic                  res_err;
    logic [DATA_W-1:0]     res_data;
    logic                  dec_pending;
    logic [REG_ADDR_W-1:0] dec_rd;
    logic                  iss_fire;
    logic [CNT_W-1:0]      cnt [REG_NUM];
    logic [REG_NUM-1:1]    inc_vec;
    logic [REG_NUM-1:1]    dec_vec;

    assign mem_ready = !rst && !wb_stall;
    assign accept    = mem_valid && mem_ready;

    wb_load_align u_align (
        .raw     (mem_result),
        .funct3  (mem_funct3),
        .addr_lo (mem_addr_lo),
        .data    (ld_data),
        .err     (ld_bad)
    );

    assign res_err  = mem_is_load && ld_bad;
    assign res_data = mem_is_load ? ld_data : mem_result;

    // Write port. dec_pending trails the accept by one edge so the counter
    // decrements at the edge that ends the we cycle; errored loads still
    // retire their scoreboard entry even though nothing is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            we          <= 1'b0;
            waddr       <= '0;
            wdata       <= '0;
            ld_err      <= 1'b0;
            dec_pending <= 1'b0;
            dec_rd      <= '0;
        end else begin
            we          <= 1'b0;
            ld_err      <= 1'b0;
            dec_pending <= 1'b0;
            if (accept) begin
                waddr       <= mem_rd;
                wdata       <= res_data;
                we          <= mem_rd_we && (mem_rd != '0) && !res_err;
                ld_err      <= res_err;
                dec_pending <= mem_rd_we && (mem_rd != '0);
                dec_rd      <= mem_rd;
            end
        end
    end

    // Scoreboard
    assign iss_ready = !rst && ((iss_rd == '0) || (cnt[iss_rd] != CNT_MAX));
    assign iss_fire  = iss_valid && iss_ready && (iss_rd != '0);

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 1; i < REG_NUM; i++) begin
            inc_vec[i] = iss_fire && (iss_rd == REG_ADDR_W'(i));
            dec_vec[i] = dec_pending && (dec_rd == REG_ADDR_W'(i));
        end
    end

    // Simultaneous issue and retire cancel; a retire with nothing in
    // flight saturates at zero rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) cnt[i] <= '0;
        end else begin
            cnt[0] <= '0;
            for (int i = 1; i < REG_NUM; i++) begin
                if (inc_vec[i] && !dec_vec[i])
                    cnt[i] <= cnt[i] + CNT_W'(1);
                else if (dec_vec[i] && !inc_vec[i] && (cnt[i] != '0))
                    cnt[i] <= cnt[i] - CNT_W'(1);
            end
        end
    end

    // The register file bypasses wdata during the we cycle, so the last
    // outstanding write to a register no longer counts as busy then.
    assign q_busy1 = (q_r1 != '0) && (cnt[q_r1] != '0) &&
                     !(we && (waddr == q_r1) && (cnt[q_r1] == CNT_W'(1)));
    assign q_busy2 = (q_r2 != '0) && (cnt[q_r2] != '0) &&
                     !(we && (waddr == q_r2) && (cnt[q_r2] == CNT_W'(1)));

`ifdef WB_INSTRET_EN
    always_ff @(posedge clk) begin
        if (rst)         instret <= '0;
        else if (accept) instret <= instret + 64'd1;
    end
`endif

endmodule

// File: tb/tb_wb_commit.sv
module tb_wb_commit;
    import wb_commit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_ready, mem_rd_we, mem_is_load;
    logic [4:0]  mem_rd;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_result;
    logic        wb_stall;
    logic        we, ld_err;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        iss_valid, iss_ready;
    logic [4:0]  iss_rd, q_r1, q_r2;
    logic        q_busy1, q_busy2;
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
    longint      exp_instret = 0;
`endif

    wb_commit #(.CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd_we(mem_rd_we),
        .mem_rd(mem_rd), .mem_is_load(mem_is_load), .mem_funct3(mem_funct3),
        .mem_addr_lo(mem_addr_lo), .mem_result(mem_result), .wb_stall(wb_stall),
        .we(we), .waddr(waddr), .wdata(wdata), .ld_err(ld_err),
`ifdef WB_INSTRET_EN
        .instret(instret),
`endif
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .q_r1(q_r1), .q_r2(q_r2), .q_busy1(q_busy1), .q_busy2(q_busy2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    localparam logic [31:0] RAW = 32'h80FF_7F01;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write or error pulse must match the head of the queue.
    always @(negedge clk) begin
        if (we === 1'b1 || ld_err === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: we=%0b waddr=%0d wdata=%0h ld_err=%0b expected none",
                         we, waddr, wdata, ld_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("mon_we", we, e.we);
                check("mon_ld_err", ld_err, e.err);
                check("mon_waddr", waddr, e.addr);
                check("mon_wdata", wdata, e.data);
                check("mon_latency_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one result for one cycle (assumes mem_ready); returns in the
    // output cycle of that result.
    task automatic do_mem(input logic [4:0] rd, input logic rd_we, input logic is_ld,
                          input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] res,
                          input logic exp_we, input logic [31:0] exp_data, input logic exp_err);
        exp_t e;
        mem_valid = 1'b1; mem_rd = rd; mem_rd_we = rd_we; mem_is_load = is_ld;
        mem_funct3 = f3; mem_addr_lo = lo; mem_result = res;
        if (exp_we || exp_err) begin
            e.we = exp_we; e.addr = rd; e.data = exp_data; e.err = exp_err; e.cyc = cyc + 1;
            exp_q.push_back(e);
        end
`ifdef WB_INSTRET_EN
        exp_instret++;
`endif
        tick();
        mem_valid = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic exp_rdy);
        iss_valid = 1'b1; iss_rd = rd;
        @(negedge clk);
        check("iss_ready", iss_ready, exp_rdy);
        tick();
        iss_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; mem_valid = 1'b0; mem_rd_we = 1'b0; mem_rd = '0; mem_is_load = 1'b0;
        mem_funct3 = '0; mem_addr_lo = '0; mem_result = '0; wb_stall = 1'b0;
        iss_valid = 1'b0; iss_rd = '0; q_r1 = '0; q_r2 = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_ready", mem_ready, 1'b0);
        check("rst_iss_ready", iss_ready, 1'b0);
        check("rst_we", we, 1'b0);
        check("rst_waddr", waddr, 5'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_ld_err", ld_err, 1'b0);
`ifdef WB_INSTRET_EN
        check("rst_instret", instret, 64'd0);
`endif
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mem_ready_idle", mem_ready, 1'b1);
        check("iss_ready_idle", iss_ready, 1'b1);
        tick();

        // Plain ALU result, one-cycle latency, single-cycle we
        do_mem(5, 1, 0, 3'b000, 0, 32'h1234_5678, 1, 32'h1234_5678, 0);
        tick();
        q_r1 = 5;
        @(negedge clk);
        check("busy_r5_after_unissued_commit", q_busy1, 1'b0);
        tick();

        // Load alignment, back-to-back
        do_mem(1,  1, 1, F3_LB,  3, RAW, 1, 32'hFFFF_FF80, 0);
        do_mem(2,  1, 1, F3_LBU, 1, RAW, 1, 32'h0000_007F, 0);
        do_mem(14, 1, 1, F3_LH,  2, RAW, 1, 32'hFFFF_80FF, 0);
        do_mem(15, 1, 1, F3_LHU, 0, RAW, 1, 32'h0000_7F01, 0);
        do_mem(16, 1, 1, F3_LW,  0, RAW, 1, 32'h80FF_7F01, 0);
        do_mem(17, 1, 1, F3_LBU, 2, RAW, 1, 32'h0000_00FF, 0);
        do_mem(18, 1, 1, F3_LB,  1, RAW, 1, 32'h0000_007F, 0);
        tick();

        // Misaligned LW still retires the scoreboard entry for r7
        issue(7, 1);
        q_r1 = 7;
        @(negedge clk);
        check("busy_r7_issued", q_busy1, 1'b1);
        tick();
        do_mem(7, 1, 1, F3_LW, 2, RAW, 0, 32'h0, 1);
        @(negedge clk);
        check("busy_r7_err_cycle", q_busy1, 1'b1);
        tick();
        @(negedge clk);
        check("busy_r7_after_err", q_busy1, 1'b0);
        tick();
        do_mem(8,  1, 1, 3'b011, 0, RAW, 0, 32'h0, 1);
        do_mem(9,  1, 1, F3_LH,  1, RAW, 0, 32'h0, 1);
        do_mem(10, 1, 1, F3_LHU, 3, RAW, 0, 32'h0, 1);
        tick();

        // Saturate r3, then drain it
        issue(3, 1);
        issue(3, 1);
        issue(3, 1);
        issue(3, 0);
        q_r1 = 3; iss_rd = 3;
        do_mem(3, 1, 0, 3'b000, 0, 32'hAAAA_0001, 1, 32'hAAAA_0001, 0);
        @(negedge clk);
        check("busy_r3_cnt3", q_busy1, 1'b1);
        check("iss_ready_r3_full", iss_ready, 1'b0);
        tick();
        @(negedge clk);
        check("iss_ready_r3_after_commit", iss_ready, 1'b1);
        tick();
        do_mem(3, 1, 0, 3'b000, 0, 32'hAAAA_0002, 1, 32'hAAAA_0002, 0);
        @(negedge clk);
        check("busy_r3_cnt2_we", q_busy1, 1'b1);
        tick();
        q_r2 = 3;
        do_mem(3, 1, 0, 3'b000, 0, 32'hAAAA_0003, 1, 32'hAAAA_0003, 0);
        @(negedge clk);
        check("busy1_r3_last_we_bypass", q_busy1, 1'b0);
        check("busy2_r3_last_we_bypass", q_busy2, 1'b0);
        tick();
        @(negedge clk);
        check("busy_r3_drained", q_busy1, 1'b0);
        tick();

        // Register 0 never tracked or written
        issue(0, 1);
        q_r1 = 0; q_r2 = 0;
        do_mem(0, 1, 0, 3'b000, 0, 32'hDEAD_BEEF, 0, 32'h0, 0);
        @(negedge clk);
        check("busy1_r0", q_busy1, 1'b0);
        check("busy2_r0", q_busy2, 1'b0);
        check("waddr_r0_loaded", waddr, 5'd0);
        check("wdata_r0_loaded", wdata, 32'hDEAD_BEEF);
        tick();
        do_mem(10, 0, 0, 3'b000, 0, 32'h0000_0055, 0, 32'h0, 0);
        @(negedge clk);
        check("waddr_nowrite_loaded", waddr, 5'd10);
        check("wdata_nowrite_loaded", wdata, 32'h0000_0055);
        tick();

        // Stall blocks accept
        wb_stall = 1'b1; mem_valid = 1'b1; mem_rd = 9; mem_rd_we = 1'b1;
        mem_is_load = 1'b0; mem_result = 32'h1111_1111;
        @(negedge clk);
        check("stall_mem_ready", mem_ready, 1'b0);
        tick();
        @(negedge clk);
        check("stall_mem_ready_2", mem_ready, 1'b0);
        check("stall_waddr_hold", waddr, 5'd10);
        check("stall_wdata_hold", wdata, 32'h0000_0055);
        tick();
        mem_valid = 1'b0; wb_stall = 1'b0;
`ifdef WB_INSTRET_EN
        @(negedge clk);
        check("instret_count", instret, exp_instret);
        tick();
`endif

        // Reset with r4 partially full and a result in flight
        issue(4, 1);
        issue(4, 1);
        q_r2 = 4;
        @(negedge clk);
        check("busy_r4_cnt2", q_busy2, 1'b1);
        tick();
        rst = 1'b1; mem_valid = 1'b1; mem_rd = 4; mem_rd_we = 1'b1; mem_result = 32'h2222_2222;
        tick();
        @(negedge clk);
        check("midrst_mem_ready", mem_ready, 1'b0);
        check("midrst_we", we, 1'b0);
        tick();
        rst = 1'b0; mem_valid = 1'b0;
`ifdef WB_INSTRET_EN
        exp_instret = 0;
`endif
        @(negedge clk);
        check("post_rst_busy_r4", q_busy2, 1'b0);
        check("post_rst_we", we, 1'b0);
        check("post_rst_waddr", waddr, 5'd0);
`ifdef WB_INSTRET_EN
        check("post_rst_instret", instret, 64'd0);
`endif
        tick();
        issue(4, 1);
        issue(4, 1);
        issue(4, 1);
        issue(4, 0);

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_commit.md
Name: wb_commit

Overview:
- Writeback/commit stage: the producer side of the register-file write port.
- Accepts completed results from the MEM stage over a valid/ready handshake and aligns and sign-extends load data.
- Drives we/waddr/wdata into the register file as a registered single-cycle pulse.
- Keeps a per-register pending-write scoreboard that decode queries before reading operands.

Parameters:
- CNT_W, 2, width of each per-register in-flight counter; max in-flight writes per rd = 2^CNT_W-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- mem_valid  in  1  MEM-stage result valid
- mem_ready  out  1  stage can accept a result
- mem_rd_we  in  1  result writes a register
- mem_rd  in  `RegAddrBus  destination register
- mem_is_load  in  1  result is raw load word
- mem_funct3  in  3  load type (RV32I encoding)
- mem_addr_lo  in  2  load byte address [1:0]
- mem_result  in  `DataBus  ALU result or raw aligned memory word
- wb_stall  in  1  hold stage (debug halt)
- we  out  1  register-file write enable
- waddr  out  `RegAddrBus  register-file write address
- wdata  out  `DataBus  register-file write data
- ld_err  out  1  one-cycle pulse: misaligned or unsupported load
- iss_valid  in  1  decode issuing an instruction that writes iss_rd
- iss_rd  in  `RegAddrBus  issuing destination
- iss_ready  out  1  scoreboard can accept the issue
- q_r1, q_r2  in  `RegAddrBus  decode source registers
- q_busy1, q_busy2  out  1  source has an uncommitted write

Behaviour:
- Reset (rst=1 at edge): we=0, waddr=0, wdata=0, ld_err=0, all counters=0, dec_pending=0. mem_ready=0 and iss_ready=0 while rst is high. Reset mid-transaction discards everything.
- mem_ready = !rst && !wb_stall. Accept = mem_valid && mem_ready.
- Latency: outputs are registered one cycle after accept. we is high for exactly one cycle per accepted write; it is never held during a stall.
- Write rule: we = mem_rd_we && mem_rd!=0 && !error. waddr and wdata are loaded on every accept. When nothing is accepted, waddr and wdata hold and we=0.
- Non-load result: wdata = mem_result.
- Load extraction by funct3:
  - 000 LB: byte at addr_lo, sign-extended.
  - 100 LBU: byte at addr_lo, zero-extended.
  - 001 LH: halfword at addr_lo[1], sign-extended.
  - 101 LHU: halfword at addr_lo[1], zero-extended.
  - 010 LW: full word.
- Load errors: LH/LHU with addr_lo[0]=1, LW with addr_lo!=0, or any other funct3. Result: wdata=0, we=0, ld_err=1 for one cycle.
- Scoreboard: one CNT_W-bit counter per register; register 0 has no counter (always 0).
  - Issue fire = iss_valid && iss_ready && iss_rd!=0; increments cnt[iss_rd].
  - iss_ready = !rst && (iss_rd==0 || cnt[iss_rd] != max).
  - Every accept with mem_rd_we && mem_rd!=0 sets dec_pending with that rd, including errored loads. The following edge decrements cnt[rd], i.e. the edge ending the we cycle.
  - Issue and decrement on the same register at the same edge: counter unchanged.
  - A decrement with cnt=0 is a protocol violation; the counter stays 0 and does not wrap.
- Query: q_busyN = (q_rN!=0) && cnt[q_rN]!=0 && !(we && waddr==q_rN && cnt[q_rN]==1). The register file bypasses wdata in the we cycle, so the last outstanding write is not busy.

Optional Feature:
- Macro WB_INSTRET_EN.
- Defined: adds output instret [63:0]; reset to 0; increments by 1 per accepted result, including non-writing and errored ones; wraps modulo 2^64.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- cpu/define.v gains load funct3 constants (`LB, `LH, `LW, `LBU, `LHU) and a `CntBus width macro, alongside existing `DataBus, `RegAddrBus, `RegNum.
- One natural sub-module: wb_load_align, purely combinational (raw word, funct3, addr_lo -> data, err).
- The scoreboard stays inline.

Test Plan:
- Reset 3 cycles, then mem_valid with rd=5, result 0x1234_5678, non-load -> exactly one cycle later we=1, waddr=5, wdata=0x12345678; next cycle we=0.
- Loads of raw 0x80FF_7F01 -> LB addr_lo=3 gives 0xFFFFFF80; LBU addr_lo=1 gives 0x0000007F; LH addr_lo=2 gives 0xFFFF80FF; LHU addr_lo=0 gives 0x00007F01.
- LW addr_lo=2, rd=7 -> we=0, ld_err pulse, cnt[7] still decremented (q_busy1 for r7 drops after issue+commit).
- Issue rd=3 three times -> iss_ready=0 on 4th. Commit one -> iss_ready=1. During the final commit's we cycle, q_busy1(r3)=0.
- Issue rd=0, and mem_rd=0 write -> counters unchanged, we=0, q_busy for r0 always 0.
- wb_stall high with mem_valid -> mem_ready=0, no we. Assert rst while cnt[4]=2 -> next cycle all counters 0, we=0, (instret=0 if WB_INSTRET_EN).
